// File: rtl/bcd_stopwatch.sv
// Two-digit BCD seconds stopwatch (00-59) with tick prescaler, start/stop toggle,
// synchronous clear and up/down direction. Feeds the 7-segment decoders and minutes stage.
module bcd_stopwatch #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clr,
    input  logic       dir,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       run,
    output logic       wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          prev;
    logic          start_edge;
    logic          step;
    logic [PW-1:0] presc;
    logic [8:0]    bcd_nxt;

    // Next {wrap, tens, ones} for one count step; wraps 59<->00.
    function automatic logic [8:0] bcd_step(input logic [3:0] o,
                                            input logic [3:0] t,
                                            input logic       down);
        logic [8:0] r;
        if (!down) begin
            if (o < 4'd9)
                r = {1'b0, t, o + 4'd1};
            else if (t < 4'd5)
                r = {1'b0, t + 4'd1, 4'd0};
            else
                r = {1'b1, 4'd0, 4'd0};
        end else begin
            if (o != 4'd0)
                r = {1'b0, t, o - 4'd1};
            else if (t != 4'd0)
                r = {1'b0, t - 4'd1, 4'd9};
            else
                r = {1'b1, 4'd5, 4'd9};
        end
        return r;
    endfunction

    // prev resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prev <= 1'b1;
        else
            prev <= start_stop;
    end

    assign start_edge = start_stop & ~prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= STOPPED;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr)
            state_nxt = STOPPED;
        else if (start_edge)
            state_nxt = (state == RUNNING) ? STOPPED : RUNNING;
    end

    // A stop edge or clear coinciding with the terminal count suppresses the step.
    always_comb begin
        run  = (state == RUNNING);
        step = (state == RUNNING) && (presc == PMAX) && !start_edge && !clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (clr || start_edge || (state != RUNNING) || (presc == PMAX))
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    assign bcd_nxt = bcd_step(ones, tens, dir);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= 4'd0;
            tens <= 4'd0;
            wrap <= 1'b0;
        end else if (clr) begin
            ones <= 4'd0;
            tens <= 4'd0;
            wrap <= 1'b0;
        end else if (step) begin
            ones <= bcd_nxt[3:0];
            tens <= bcd_nxt[7:4];
            wrap <= bcd_nxt[8];
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch (TICK_DIV=4): segment table driven against a seconds-counter
// model whose per-cycle expectations pass through a scoreboard queue.
`timescale 1ns/1ps
module tb_bcd_stopwatch;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_stop;
    logic       clr;
    logic       dir;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       run;
    logic       wrap;

    bcd_stopwatch #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clr        (clr),
        .dir        (dir),
        .ones       (ones),
        .tens       (tens),
        .run        (run),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sec;
        bit run;
        bit wrap;
    } exp_t;

    typedef struct {
        bit    arst;
        bit    ss;
        bit    clr;
        bit    dir;
        int    n;
        int    sec;
        bit    run;
        bit    wrap;
        string name;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    int nvec = 0;
    int nmis = 0;

    int m_sec;
    int m_cnt;
    bit m_run;
    bit m_wrap;
    bit m_prev;

    task automatic model_reset();
        m_sec  = 0;
        m_cnt  = 0;
        m_run  = 0;
        m_wrap = 0;
        m_prev = 1;
    endtask

    task automatic model_edge(input bit ss, input bit c, input bit d);
        bit se;
        se     = ss && !m_prev;
        m_prev = ss;
        m_wrap = 0;
        if (c) begin
            m_sec = 0;
            m_run = 0;
            m_cnt = 0;
        end else if (se) begin
            m_run = !m_run;
            m_cnt = 0;
        end else if (m_run) begin
            if (m_cnt == TD - 1) begin
                m_cnt = 0;
                if (d) begin
                    if (m_sec == 0) begin m_sec = 59; m_wrap = 1; end
                    else m_sec = m_sec - 1;
                end else begin
                    if (m_sec == 59) begin m_sec = 0; m_wrap = 1; end
                    else m_sec = m_sec + 1;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic check(input string name, input int sec, input bit r, input bit w);
        nvec++;
        if (ones > 4'd9 || tens > 4'd5 ||
            tens !== 4'(sec / 10) || ones !== 4'(sec % 10) ||
            run !== r || wrap !== w) begin
            nmis++;
            $display("FAIL %s: got %0d%0d run=%0b wrap=%0b, want %02d run=%0b wrap=%0b",
                     name, tens, ones, run, wrap, sec, r, w);
        end
    endtask

    task automatic cycle(input string name);
        exp_t e;
        model_edge(start_stop, clr, dir);
        sb.push_back('{m_sec, m_run, m_wrap});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(name, e.sec, e.run, e.wrap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want $finish before it");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start_stop = 1'b1;
        clr        = 1'b0;
        dir        = 1'b0;
        model_reset();

        //             arst ss clr dir   n  sec run wrap name
        tbl.push_back('{0, 1, 0, 0,   3,  0, 0, 0, "held_thru_reset"});
        tbl.push_back('{0, 0, 0, 0,   1,  0, 0, 0, "release_btn"});
        tbl.push_back('{0, 1, 0, 0,   1,  0, 1, 0, "start"});
        tbl.push_back('{0, 1, 0, 0,   4,  1, 1, 0, "first_step"});
        tbl.push_back('{0, 0, 0, 0, 236,  0, 1, 1, "up_wrap"});
        tbl.push_back('{0, 0, 1, 0,   1,  0, 0, 0, "clr"});
        tbl.push_back('{0, 0, 0, 1,   1,  0, 0, 0, "dir_down"});
        tbl.push_back('{0, 1, 0, 1,   1,  0, 1, 0, "start_down"});
        tbl.push_back('{0, 1, 0, 1,   4, 59, 1, 1, "down_wrap"});
        tbl.push_back('{0, 1, 0, 1,  36, 50, 1, 0, "down_to_50"});
        tbl.push_back('{0, 1, 0, 1,   4, 49, 1, 0, "down_50_49"});
        tbl.push_back('{0, 0, 1, 0,   1,  0, 0, 0, "clr2"});
        tbl.push_back('{0, 1, 0, 0,   1,  0, 1, 0, "start_up"});
        tbl.push_back('{0, 1, 0, 0,  28,  7, 1, 0, "up_to_07"});
        tbl.push_back('{0, 0, 0, 0,   2,  7, 1, 0, "into_interval"});
        tbl.push_back('{0, 1, 0, 0,   1,  7, 0, 0, "stop_at_07"});
        tbl.push_back('{0, 0, 0, 0,  20,  7, 0, 0, "hold_07"});
        tbl.push_back('{0, 1, 0, 0,   1,  7, 1, 0, "restart"});
        tbl.push_back('{0, 1, 0, 0,   3,  7, 1, 0, "restart_wait"});
        tbl.push_back('{0, 1, 0, 0,   1,  8, 1, 0, "restart_step"});
        tbl.push_back('{0, 0, 0, 0, 116, 37, 1, 0, "up_to_37"});
        tbl.push_back('{0, 1, 1, 0,   1,  0, 0, 0, "clr_with_edge"});
        tbl.push_back('{0, 0, 0, 0,   1,  0, 0, 0, "idle"});
        tbl.push_back('{0, 1, 0, 0,   1,  0, 1, 0, "start3"});
        tbl.push_back('{0, 0, 0, 0,   3,  0, 1, 0, "to_terminal"});
        tbl.push_back('{0, 1, 0, 0,   1,  0, 0, 0, "stop_on_step"});
        tbl.push_back('{0, 0, 0, 0,   1,  0, 0, 0, "idle2"});
        tbl.push_back('{0, 1, 0, 0,   1,  0, 1, 0, "start4"});
        tbl.push_back('{0, 1, 0, 0, 168, 42, 1, 0, "up_to_42"});
        tbl.push_back('{0, 1, 0, 0,   2, 42, 1, 0, "mid_42"});
        tbl.push_back('{1, 1, 0, 0,  12,  0, 0, 0, "no_start_after_rst"});
        tbl.push_back('{0, 0, 0, 0,   1,  0, 0, 0, "release_btn2"});
        tbl.push_back('{0, 1, 0, 0,   1,  0, 1, 0, "start5"});
        tbl.push_back('{0, 1, 0, 0,   4,  1, 1, 0, "step_after_rst"});

        #3;
        check("in_reset", 0, 0, 0);
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].arst) begin
                // half-cycle reset pulse in the middle of an interval
                #1 rst_n = 1'b0;
                #1 check("async_rst_immediate", 0, 0, 0);
                #4 rst_n = 1'b1;
                model_reset();
            end
            start_stop = tbl[i].ss;
            clr        = tbl[i].clr;
            dir        = tbl[i].dir;
            for (int k = 0; k < tbl[i].n; k++)
                cycle(tbl[i].name);
            check({tbl[i].name, "_end"}, tbl[i].sec, tbl[i].run, tbl[i].wrap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
